// File: rtl/inert_spi_resp_if.sv
// SPI link between the inertial-interface master and the sensor responder.
interface inert_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_resp.sv
// SPI responder modelling the 6-axis inertial sensor: config registers, data readout and INT.
// Define INERT_WHOAMI_EN to add a read-only WHO_AM_I register (0x0F reads 8'h6A).
module inert_spi_resp #(
    parameter logic [6:0] DATA_BASE  = 7'h22,
    parameter logic [7:0] INT_EN_VAL = 8'h02
) (
    input  logic                clk,
    input  logic                rst_n,
    inert_spi_resp_if.slave     spi,
    output logic                INT,
    input  logic                smpl_vld,
    input  logic signed [15:0]  ptch_in,
    input  logic signed [15:0]  roll_in,
    input  logic signed [15:0]  yaw_in,
    input  logic signed [15:0]  ax_in,
    input  logic signed [15:0]  ay_in,
    output logic                cfg_done
);

    localparam logic [6:0] AddrIntEn = 7'h0D;
    localparam logic [6:0] AddrCfg10 = 7'h10;
    localparam logic [6:0] AddrCfg11 = 7'h11;
    localparam logic [6:0] AddrCfg14 = 7'h14;
    localparam logic [6:0] DataLast  = DATA_BASE + 7'd9;

    // Synchroniser chains; the third stage of SS_n/SCLK is only for edge detection.
    logic [2:0] ss_sync_q;
    logic [2:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;

    logic ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_shift;

    logic [7:0]  int_en_q, int_en_d;
    logic [7:0]  cfg10_q, cfg10_d;
    logic [7:0]  cfg11_q, cfg11_d;
    logic [7:0]  cfg14_q, cfg14_d;
    logic [3:0]  cfg_wr_q, cfg_wr_d;

    logic [79:0] data_q, data_d;
    logic [79:0] pend_buf_q, pend_buf_d;
    logic        pend_vld_q, pend_vld_d;
    logic        burst_q, burst_d;
    logic        flush_q, flush_d;
    logic        int_pend_q, int_pend_d;

    logic [79:0] sample;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_byte;

    logic        frame_ok, wr_commit, rd_commit, data_rd, last_rd, burst_now;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data;

    assign ss_low    = ~ss_sync_q[1];
    assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
    assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

    assign rx_shift = {rx_q[14:0], mosi_sync_q[1]};
    assign rd_addr  = rx_shift[6:0];
    assign cmd_addr = rx_q[14:8];
    assign cmd_data = rx_q[7:0];

    // Little-endian byte image: byte 0 is ptch low, byte 9 is ay high.
    assign sample = {ay_in, ax_in, yaw_in, roll_in, ptch_in};

    // Register read mux, addressed by the command byte as it completes.
    always_comb begin
        rd_byte = 8'h00;
        unique case (rd_addr)
            AddrIntEn: rd_byte = int_en_q;
            AddrCfg10: rd_byte = cfg10_q;
            AddrCfg11: rd_byte = cfg11_q;
            AddrCfg14: rd_byte = cfg14_q;
`ifdef INERT_WHOAMI_EN
            7'h0F:     rd_byte = 8'h6A;
`endif
            default: begin
                for (int i = 0; i < 10; i++) begin
                    if (rd_addr == DATA_BASE + 7'(i)) rd_byte = data_q[8*i +: 8];
                end
            end
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        int_en_d   = int_en_q;
        cfg10_d    = cfg10_q;
        cfg11_d    = cfg11_q;
        cfg14_d    = cfg14_q;
        cfg_wr_d   = cfg_wr_q;
        data_d     = data_q;
        pend_buf_d = pend_buf_q;
        pend_vld_d = pend_vld_q;
        burst_d    = burst_q;
        flush_d    = 1'b0;
        int_pend_d = int_pend_q;

        // Shift engine
        if (ss_fall) begin
            bit_cnt_d = 5'd0;
            tx_d      = 16'h0000;
        end else if (ss_low) begin
            if (sclk_rise) begin
                rx_d = rx_shift;
                if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7 && rx_shift[7]) tx_d = {rd_byte, 8'h00};
            end else if (sclk_fall && bit_cnt_q != 5'd8) begin
                // The fall after the address byte holds, so the loaded MSB is driven for bit 7.
                tx_d = {tx_q[14:0], 1'b0};
            end
        end

        // Frame commit
        frame_ok  = ss_rise && (bit_cnt_q == 5'd16);
        wr_commit = frame_ok & ~rx_q[15];
        rd_commit = frame_ok &  rx_q[15];
        data_rd   = rd_commit && (cmd_addr >= DATA_BASE) && (cmd_addr <= DataLast);
        last_rd   = rd_commit && (cmd_addr == DataLast);

        if (wr_commit) begin
            unique case (cmd_addr)
                AddrIntEn: begin int_en_d = cmd_data; cfg_wr_d[0] = 1'b1; end
                AddrCfg10: begin cfg10_d  = cmd_data; cfg_wr_d[1] = 1'b1; end
                AddrCfg11: begin cfg11_d  = cmd_data; cfg_wr_d[2] = 1'b1; end
                AddrCfg14: begin cfg14_d  = cmd_data; cfg_wr_d[3] = 1'b1; end
                default: ;
            endcase
        end

        // Sample handling: a burst in progress defers new samples to the pending buffer.
        burst_now = burst_q | data_rd;

        if (flush_q) begin
            data_d     = pend_buf_q;
            pend_vld_d = 1'b0;
            int_pend_d = 1'b1;
        end

        if (data_rd) burst_d = 1'b1;

        if (last_rd) begin
            burst_d    = 1'b0;
            int_pend_d = 1'b0;
            flush_d    = pend_vld_q | smpl_vld;
        end

        if (smpl_vld) begin
            if (burst_now) begin
                pend_buf_d = sample;
                pend_vld_d = 1'b1;
            end else begin
                data_d     = sample;
                int_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b111;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= 5'd0;
            rx_q        <= 16'h0000;
            tx_q        <= 16'h0000;
            int_en_q    <= 8'h00;
            cfg10_q     <= 8'h00;
            cfg11_q     <= 8'h00;
            cfg14_q     <= 8'h00;
            cfg_wr_q    <= 4'b0000;
            data_q      <= 80'h0;
            pend_buf_q  <= 80'h0;
            pend_vld_q  <= 1'b0;
            burst_q     <= 1'b0;
            flush_q     <= 1'b0;
            int_pend_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[1:0], spi.SS_n};
            sclk_sync_q <= {sclk_sync_q[1:0], spi.SCLK};
            mosi_sync_q <= {mosi_sync_q[0], spi.MOSI};
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            int_en_q    <= int_en_d;
            cfg10_q     <= cfg10_d;
            cfg11_q     <= cfg11_d;
            cfg14_q     <= cfg14_d;
            cfg_wr_q    <= cfg_wr_d;
            data_q      <= data_d;
            pend_buf_q  <= pend_buf_d;
            pend_vld_q  <= pend_vld_d;
            burst_q     <= burst_d;
            flush_q     <= flush_d;
            int_pend_q  <= int_pend_d;
        end
    end

    assign spi.MISO = ss_low & tx_q[15];
    assign INT      = int_pend_q & (int_en_q == INT_EN_VAL);
    assign cfg_done = &cfg_wr_q;

endmodule

// File: doc/inert_spi_resp.md
Name: inert_spi_resp

Overview:
- SPI responder (serf) end of the inertial-sensor link; models the 6-axis sensor that the master-side inertial interface talks to.
- Decodes 16-bit command frames, writes the configuration registers, and returns data-register bytes on MISO.
- Asserts INT when a new sample is available.
- Used in the full-chip testbench and in FPGA loopback tests.
- Sample data enters through a parallel load port driven by the stimulus/physics model.

Parameters:
- DATA_BASE, 7'h22, address of the first data register (ptch low byte); ten consecutive byte registers follow.
- INT_EN_VAL, 8'h02, value that must be written to address 0x0D to enable INT.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  SPI serf select, active low
- SCLK  in  1  SPI clock; idles high
- MOSI  in  1  master-out data
- MISO  out  1  serf-out data
- INT  out  1  new-data interrupt, active high
- smpl_vld  in  1  one-cycle pulse; load the sample inputs
- ptch_in, roll_in, yaw_in, ax_in, ay_in  in  16 each  signed sample values
- cfg_done  out  1  high once all four config registers (0x0D, 0x10, 0x11, 0x14) have been written

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-low, named rst_n.
- Input synchronisation: SS_n, SCLK and MOSI are each double-flopped into clk. SCLK rise and fall are detected from the synchronised copies. SCLK high time is at least 4 clk.

Frame format:
- MSB first, 16 bits per frame.
- Bit15 = 1 means read, 0 means write. Bits 14:8 = address. Bits 7:0 = write data, ignored on reads.
- MOSI is sampled on SCLK rise. MISO changes on SCLK fall.

Shift/count:
- Synchronised SS_n fall clears the bit counter and loads the MISO shifter with 16'h0000.
- After 8 rises (address byte complete), if the frame is a read, shifter bits [15:8] are loaded with the addressed register. This happens before the 9th SCLK fall, so the returned byte occupies frame bits 7:0.
- Unmapped addresses return 8'h00.
- MISO = shifter[15] while SS_n is low, otherwise 0.

Frame commit:
- A frame commits on the synchronised SS_n rise, only if exactly 16 rises were counted.
- Any other count discards the frame: no register write, no read side effects.

Registers:
- Config registers 0x0D, 0x10, 0x11, 0x14 are 8-bit read/write; reset 8'h00.
- Data registers DATA_BASE..DATA_BASE+9 are read-only, little-endian byte order: ptch L/H, roll L/H, yaw L/H, ax L/H, ay L/H. Reset 8'h00.

cfg_done:
- Sticky per-address written flags; cfg_done = AND of the four flags.
- Reset 0.

Sample load:
- On smpl_vld with no burst active, the 80-bit sample goes into the data registers next clk and int_pend is set.
- Burst active = any data register read committed since INT last rose.
- smpl_vld during a burst stores the sample in a pending buffer. The buffer commits when the burst ends, and INT re-asserts 1 clk later.
- A second smpl_vld during the same burst overwrites the pending buffer; the last sample wins.

INT:
- INT = int_pend AND (reg 0x0D == INT_EN_VAL).
- int_pend clears on commit of a read of DATA_BASE+9; this ends the burst.
- If smpl_vld coincides with that commit, the sample is treated as pending: commit, then INT=1.

Reset values:
- MISO=0, INT=0, cfg_done=0.
- Shifter, counter, pending buffer and flags all cleared.

Reset mid-frame:
- Everything clears, partial frame lost.
- The next SS_n fall starts a clean frame.

Optional Feature:
- Macro: INERT_WHOAMI_EN.
- Defined: read-only address 0x0F returns 8'h6A. A write to 0x0F is ignored and does not affect cfg_done.
- Undefined: 0x0F is unmapped and reads 8'h00.

Test Plan:
1. Reset, then write frames 0x0D02, 0x1062, 0x1162, 0x1460 → cfg_done rises after the 4th SS_n rise; reading frame 0x8D00 returns MISO byte 8'h02.
2. Config done; smpl_vld with ptch_in=16'h1234, ay_in=16'hFEDC → INT=1 within 2 clk. Read burst 0xA2..0xAB returns 34,12,…,DC,FE. INT falls after the 0xAB frame commits.
3. Without the 0x0D write, smpl_vld → INT stays 0. A later write of 0x0D02 → INT=1.
4. smpl_vld (ptch 16'h0001) mid-burst after 0xA2 is read → 0xA3 still returns 8'h00 (old value). After 0xAB, INT re-rises and 0xA2 returns 8'h01.
5. SS_n raised after 9 SCLK edges on frame 0x0D02 → register 0x0D unchanged (reads 00); the next full frame works normally.
6. rst_n pulsed low mid-frame → INT=0, MISO=0, cfg_done=0. With INERT_WHOAMI_EN defined, reading 0x8F00 returns 8'h6A; with it undefined, the same read returns 8'h00.
